// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA register-write path.
package vga_pkg;

  localparam int unsigned VACTIVE = 480;
  localparam int unsigned REG_W   = 8;
  localparam int unsigned REG_AW  = 3;

  typedef enum logic {
    IDLE,
    WRITE
  } wr_state_t;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_W-1:0]  data;
    logic              last;
  } reg_cmd_t;

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous FIFO of register commands; head entry is visible combinationally.
module reg_cmd_fifo
  import vga_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  reg_cmd_t      i_cmd,
  input  logic          i_pop,
  output reg_cmd_t      o_head,
  output logic [CW-1:0] o_count
);

  reg_cmd_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign w_push_ok = i_push && (r_count != CW'(DEPTH));
  assign w_pop_ok  = i_pop && (r_count != '0);
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_cmd;
    end
  end

  // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vga_reg_writer.sv
// Avalon-MM register writer: issues queued batches as back-to-back writes.
// Optional vblank gating via `define VGA_REG_WRITER_VBLANK_GATE_EN.
module vga_reg_writer
  import vga_pkg::*;
#(
  parameter  int unsigned DEPTH  = 8,
  parameter  int unsigned ADDR_W = 3,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              vblank,
  output logic              chipselect,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic              batch_done,
  output logic              batch_err,
  output logic [CW-1:0]     fifo_count
);

  wr_state_t         r_state;
  logic [CW-1:0]     r_nbatch;
  logic              r_forced;
  logic              r_fin;
  logic              r_write;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writedata;
  logic              r_batch_done;
  logic              r_batch_err;

  logic              w_gate;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_start_norm;
  logic              w_start_force;
  logic              w_forced_now;
  logic              w_fin;
  reg_cmd_t          w_cmd;
  reg_cmd_t          w_head;

`ifdef VGA_REG_WRITER_VBLANK_GATE_EN
  assign w_gate = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_gate          = 1'b1;
`endif

  assign in_ready   = fifo_count < CW'(DEPTH);
  assign w_push     = in_valid && in_ready;
  assign w_full     = fifo_count == CW'(DEPTH);
  assign w_empty    = fifo_count == '0;
  assign w_cmd.addr = REG_AW'(in_addr);
  assign w_cmd.data = REG_W'(in_data);
  assign w_cmd.last = in_last;

  reg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_cmd   (w_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (fifo_count)
  );

  assign w_start_norm  = (r_nbatch != '0) && w_gate;
  assign w_start_force = w_full && (r_nbatch == '0) && w_gate;

  // The first entry is popped in the IDLE cycle that starts a batch; WRITE
  // then pops until the final entry has gone, and spends one more cycle
  // presenting it, which yields the mandatory idle gap between batches.
  always_comb begin
    w_pop        = 1'b0;
    w_forced_now = r_forced;
    case (r_state)
      IDLE: begin
        w_pop        = w_start_norm || w_start_force;
        w_forced_now = w_start_force && !w_start_norm;
      end
      WRITE: begin
        w_pop = !r_fin && !w_empty;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  assign w_fin = w_pop && (w_head.last ||
                 (w_forced_now && (fifo_count == CW'(1)) && !w_push));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_nbatch     <= '0;
      r_forced     <= 1'b0;
      r_fin        <= 1'b0;
      r_write      <= 1'b0;
      r_address    <= '0;
      r_writedata  <= '0;
      r_batch_done <= 1'b0;
      r_batch_err  <= 1'b0;
    end else begin
      if ((w_push && in_last) && !(w_pop && w_head.last)) begin
        r_nbatch <= r_nbatch + CW'(1);
      end else if (!(w_push && in_last) && (w_pop && w_head.last)) begin
        r_nbatch <= r_nbatch - CW'(1);
      end

      r_write      <= w_pop;
      r_batch_done <= w_pop && w_head.last;
      r_fin        <= w_fin;
      if (w_pop) begin
        r_address   <= ADDR_W'(w_head.addr);
        r_writedata <= DATA_W'(w_head.data);
      end

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= WRITE;
            r_forced <= w_forced_now;
            if (w_forced_now) begin
              r_batch_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!w_pop) begin
            r_state  <= IDLE;
            r_forced <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign write      = r_write;
  assign chipselect = r_write;
  assign address    = r_address;
  assign writedata  = r_writedata;
  assign batch_done = r_batch_done;
  assign batch_err  = r_batch_err;

endmodule

// File: doc/vga_reg_writer.md
# vga_reg_writer

- Avalon-MM write initiator that drives the register port of the VGA display peripheral (`chipselect`, `write`, `address`, `writedata`).
- Game logic pushes register updates (address, data, batch-end flag) into an internal FIFO.
- The block issues each complete batch as back-to-back single-cycle writes, starting only inside vertical blanking, so a colour/position update never lands mid-frame.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `ADDR_W`, 3: register address width.
- `DATA_W`, 8: register data width.
- `clk` in 1: system clock (50 MHz domain of the VGA counters).
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: update offered.
- `in_ready` out 1: FIFO can accept; combinational, `count < DEPTH`.
- `in_addr` in `ADDR_W`: target register.
- `in_data` in `DATA_W`: register value.
- `in_last` in 1: entry closes a batch.
- `vblank` in 1: level, high while `vcount >= 480`.
- `chipselect` out 1: registered; equal to `write`.
- `write` out 1: registered write strobe.
- `address` out `ADDR_W`: registered.
- `writedata` out `DATA_W`: registered.
- `batch_done` out 1: registered pulse, coincident with a batch's final write.
- `batch_err` out 1: sticky flag; cleared only by reset.
- `fifo_count` out `$clog2(DEPTH)+1`: current occupancy.

## Operation
- **Push:** an entry is accepted when `in_valid && in_ready`. A full FIFO does not accept a push even if a pop happens in the same cycle.
- **Batch counter `nbatch`:**
  - +1 on an accepted push with `in_last`.
  - −1 on a pop of an entry with `last`.
  - Both in the same cycle: unchanged.
- **State IDLE:**
  - Go to WRITE when `nbatch > 0 && gate`.
  - Also go to WRITE in the forced case: FIFO full, `nbatch == 0`, and `gate`. This sets `batch_err`.
  - `gate` is `vblank`, or 1 when the gating feature is compiled out.
- **State WRITE:**
  - Pop the head entry every cycle and present it on the outputs with `write = chipselect = 1`.
  - Return to IDLE after popping an entry with `last`; `batch_done` is 1 for that write.
  - In a forced drain, also return to IDLE when the FIFO goes empty. `batch_done` stays 0 in that case.
- A batch that has started always completes, even if `vblank` falls during it.
- Writes are never split, reordered, or merged.
- **Idle outputs:** when no write is issued, `write = chipselect = 0`. `address` and `writedata` hold their last values.
- **Reset values:** FIFO empty, `nbatch = 0`, IDLE, all outputs 0, `batch_err = 0`. Reset during a batch discards every queued and in-flight entry.
- Pointers wrap modulo `DEPTH`.

## Timing
- If the IDLE start condition is true in cycle t, the first write is high in t+1. An N-entry batch writes in t+1 through t+N.
- State is IDLE in t+N+1 with `write` low. There is always at least one idle cycle between batches.
- The next batch's first write comes no earlier than t+N+2.
- **Push-to-FIFO:** an entry pushed in cycle t is poppable from t+1. A single-entry batch pushed in t during vblank writes at t+2 at the earliest.
- `in_ready` rises in the cycle after a pop that frees space.
- `vblank` is sampled only in IDLE.

## Configuration
- `VGA_REG_WRITER_VBLANK_GATE_EN`
  - **Defined:** batches start only while `vblank = 1`.
  - **Undefined:** `gate` is tied to 1 and `vblank` is ignored. Batches drain as soon as they are complete, and the forced drain starts immediately. All other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - `wr_state_t` enum: IDLE, WRITE.
  - `reg_cmd_t` struct: `addr`, `data`, `last`.
  - Constants `VACTIVE = 480`, `REG_W = 8`.
- Sub-module `reg_cmd_fifo`: synchronous FIFO of `reg_cmd_t` with push/pop/count and no read latency (head entry visible combinationally).
- The controller FSM, batch counter and output registers live in the top module.

## Test plan
- **Gated batch:** with `vblank = 0`, push batch {(0,0x12),(1,0x34),(2,0x56,last)}, then raise `vblank` at cycle t. Expect `write` high in t+1 to t+3 with `address` 0,1,2 and `writedata` 0x12,0x34,0x56, and `batch_done` only at t+3.
- **No write outside vblank:** push 3 complete batches with `vblank = 0` for 1000 cycles. Expect no `write` and `fifo_count` = number of entries pushed. Then raise `vblank` and expect three bursts, each separated by exactly one idle cycle.
- **vblank falls mid-batch:** start a 4-entry batch and drop `vblank` after the first write. Expect all 4 writes to complete; a second pending batch waits for the next `vblank`.
- **Forced drain:** push 8 entries with no `last` (`DEPTH = 8`) during vblank. Expect `in_ready = 0`, `batch_err = 1`, 8 writes, `batch_done = 0`, and the FIFO empty afterwards.
- **Boundary and reset:**
  - Push on a full FIFO during a simultaneous pop: the push is not accepted.
  - Assert `reset` mid-batch: next cycle all outputs 0 and `fifo_count = 0`, with no further writes.
  - Compiled without the macro: writes occur with `vblank = 0`.
